// File: rtl/distribute_1x2_buf.sv
// One-to-two distributor: each accepted word is routed by i_cmd into the low FIFO, the high FIFO, both, or none.
// The two branch FIFOs are independent and drain on their own i_ready bit.
module distribute_1x2_buf #(
  parameter int DATA_WIDTH     = 32,
  parameter int COMMMAND_WIDTH = 2,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid,
  input  logic [DATA_WIDTH-1:0]     i_data_bus,
  output logic                      o_ready,
  input  logic                      i_en,
  input  logic [COMMMAND_WIDTH-1:0] i_cmd,
  output logic [1:0]                o_valid,
  output logic [2*DATA_WIDTH-1:0]   o_data_bus,
  input  logic [1:0]                i_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [1:0] full;
  logic [1:0] push;
  logic [1:0] pop;
  logic       accept;

  // cmd bit 0 selects the low branch, bit 1 the high branch; a multicast needs room in both
  assign o_ready = ~rst & i_en & ~(i_cmd[0] & full[0]) & ~(i_cmd[1] & full[1]);
  assign accept  = i_valid & o_ready;

  genvar b;
  generate
    for (b = 0; b < 2; b++) begin : g_br
      logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
      logic [AW-1:0]         rd_q, rd_d;
      logic [AW-1:0]         wr_q, wr_d;
      logic [AW:0]           cnt_q, cnt_d;

      assign full[b]    = (cnt_q == (AW+1)'(FIFO_DEPTH));
      assign o_valid[b] = (cnt_q != '0);
      assign push[b]    = accept & i_cmd[b];
      assign pop[b]     = o_valid[b] & i_ready[b];
      assign o_data_bus[b*DATA_WIDTH +: DATA_WIDTH] = o_valid[b] ? mem_q[rd_q] : '0;

      always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (push[b]) wr_d = wr_q + 1'b1;
        if (pop[b])  rd_d = rd_q + 1'b1;
        case ({push[b], pop[b]})
          2'b10:   cnt_d = cnt_q + 1'b1;
          2'b01:   cnt_d = cnt_q - 1'b1;
          default: cnt_d = cnt_q;
        endcase
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_q  <= '0;
          wr_q  <= '0;
          cnt_q <= '0;
        end else begin
          rd_q  <= rd_d;
          wr_q  <= wr_d;
          cnt_q <= cnt_d;
        end
      end

      always_ff @(posedge clk) begin
        if (push[b]) mem_q[wr_q] <= i_data_bus;
      end
    end
  endgenerate

endmodule

// File: tb/tb_distribute_1x2_buf.sv
// Directed bench for distribute_1x2_buf: queue-based reference model checked every cycle,
// plus literal expectations for the reset, routing, full, multicast, drop/enable and wrap cases.
module tb_distribute_1x2_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [31:0] i_data_bus;
  logic        o_ready;
  logic        i_en;
  logic [1:0]  i_cmd;
  logic [1:0]  o_valid;
  logic [63:0] o_data_bus;
  logic [1:0]  i_ready;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] qlo[$];
  logic [31:0] qhi[$];
  logic [31:0] popped[$];
  bit          record = 1'b0;

  distribute_1x2_buf #(.DATA_WIDTH(32), .COMMMAND_WIDTH(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data_bus(i_data_bus), .o_ready(o_ready),
    .i_en(i_en), .i_cmd(i_cmd), .o_valid(o_valid), .o_data_bus(o_data_bus), .i_ready(i_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return !rst && i_en && !(i_cmd[0] && qlo.size() >= 4) && !(i_cmd[1] && qhi.size() >= 4);
  endfunction

  // reference model: a word enters a branch queue when accepted, leaves when shown and taken
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qlo.delete();
      qhi.delete();
    end else begin
      bit acc, plo, phi;
      acc = i_valid && model_ready();
      plo = qlo.size() > 0 && i_ready[0];
      phi = qhi.size() > 0 && i_ready[1];
      if (plo) void'(qlo.pop_front());
      if (phi) void'(qhi.pop_front());
      if (acc && i_cmd[0]) qlo.push_back(i_data_bus);
      if (acc && i_cmd[1]) qhi.push_back(i_data_bus);
    end
  end

  always @(negedge clk) begin
    logic [31:0] elo, ehi;
    elo = qlo.size() > 0 ? qlo[0] : 32'h0;
    ehi = qhi.size() > 0 ? qhi[0] : 32'h0;
    chk("model_o_ready", {63'h0, o_ready}, {63'h0, model_ready()});
    chk("model_o_valid", {62'h0, o_valid}, {62'h0, (qhi.size() > 0), (qlo.size() > 0)});
    chk("model_o_data", o_data_bus, {ehi, elo});
    if (record && o_valid[0] && i_ready[0]) popped.push_back(o_data_bus[31:0]);
  end

  task automatic drive(input logic v, input logic en, input logic [1:0] cmd,
                       input logic [31:0] d, input logic [1:0] rdy);
    i_valid = v; i_en = en; i_cmd = cmd; i_data_bus = d; i_ready = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx, cyc;
    bit acc;
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, cyc;
    bit acc;
    rst = 1'b1;
    drive(1'b1, 1'b1, 2'b00, 32'h0, 2'b00);
    tick(); tick();
    chk("rst_o_ready", {63'h0, o_ready}, 64'h0);
    chk("rst_o_valid", {62'h0, o_valid}, 64'h0);
    chk("rst_o_data", o_data_bus, 64'h0);

    // single routing, first push right after reset release
    rst = 1'b0;
    drive(1'b1, 1'b1, 2'b01, 32'hAAAAAAAA, 2'b00);
    tick();
    chk("route_valid_lo", {62'h0, o_valid}, 64'h1);
    chk("route_data_lo", {32'h0, o_data_bus[31:0]}, 64'hAAAAAAAA);
    drive(1'b1, 1'b1, 2'b10, 32'hBBBBBBBB, 2'b00);
    tick();
    chk("route_valid_both", {62'h0, o_valid}, 64'h3);
    chk("route_data", o_data_bus, 64'hBBBBBBBB_AAAAAAAA);

    // asynchronous reset between edges with both branches holding data
    drive(1'b0, 1'b1, 2'b00, 32'h0, 2'b00);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", {62'h0, o_valid}, 64'h0);
    chk("async_rst_data", o_data_bus, 64'h0);
    chk("async_rst_ready", {63'h0, o_ready}, 64'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_empty", {62'h0, o_valid}, 64'h0);

    // fill low branch, then push-with-pop on a full FIFO is refused
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 2'b01, 32'h10 + k, 2'b00);
      tick();
    end
    chk("full_ready", {63'h0, o_ready}, 64'h0);
    drive(1'b1, 1'b1, 2'b01, 32'h77, 2'b01);
    tick();
    chk("full_refuse_ready", {63'h0, o_ready}, 64'h1);
    chk("full_refuse_head", {32'h0, o_data_bus[31:0]}, 64'h11);
    drive(1'b0, 1'b1, 2'b01, 32'h0, 2'b01);
    tick(); tick(); tick();
    chk("full_drained", {62'h0, o_valid}, 64'h0);

    // multicast blocked by a full high branch
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 2'b10, 32'h20 + k, 2'b00);
      tick();
    end
    drive(1'b1, 1'b1, 2'b11, 32'h99, 2'b00);
    chk("mc_block_ready", {63'h0, o_ready}, 64'h0);
    tick();
    chk("mc_low_empty", {62'h0, o_valid}, 64'h2);
    drive(1'b1, 1'b1, 2'b11, 32'h99, 2'b10);
    tick();
    chk("mc_after_pop_ready", {63'h0, o_ready}, 64'h1);
    chk("mc_still_low_empty", {62'h0, o_valid}, 64'h2);
    drive(1'b1, 1'b1, 2'b11, 32'h99, 2'b00);
    tick();
    chk("mc_both_valid", {62'h0, o_valid}, 64'h3);
    chk("mc_low_data", {32'h0, o_data_bus[31:0]}, 64'h99);
    drive(1'b0, 1'b1, 2'b00, 32'h0, 2'b11);
    for (int k = 0; k < 5; k++) tick();
    chk("mc_drained", {62'h0, o_valid}, 64'h0);

    // drop code and input enable
    drive(1'b1, 1'b1, 2'b00, 32'h5A5A5A5A, 2'b00);
    chk("drop_ready", {63'h0, o_ready}, 64'h1);
    tick();
    chk("drop_no_valid", {62'h0, o_valid}, 64'h0);
    drive(1'b1, 1'b1, 2'b11, 32'h55, 2'b00);
    tick();
    drive(1'b1, 1'b1, 2'b01, 32'h66, 2'b00);
    tick();
    drive(1'b1, 1'b0, 2'b11, 32'h77, 2'b11);
    chk("en_off_ready", {63'h0, o_ready}, 64'h0);
    tick(); tick();
    chk("en_off_drained", {62'h0, o_valid}, 64'h0);

    // 12-word stream through the low branch across pointer wrap
    popped.delete();
    record = 1'b1;
    idx = 0;
    cyc = 0;
    while ((idx < 12 || qlo.size() != 0) && cyc < 200) begin
      drive(idx < 12, 1'b1, 2'b01, idx, {1'b0, cyc[0]});
      acc = (idx < 12) && o_ready;
      tick();
      if (acc) idx++;
      cyc++;
    end
    drive(1'b0, 1'b1, 2'b00, 32'h0, 2'b00);
    #1 record = 1'b0;
    chk("stream_budget", {63'h0, cyc >= 200}, 64'h0);
    chk("stream_count", popped.size(), 64'd12);
    for (int k = 0; k < 12 && k < popped.size(); k++)
      chk($sformatf("stream_word%0d", k), {32'h0, popped[k]}, k);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
